// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM states, header size, word-count type.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

   localparam int HDR_BYTES = 2;

   typedef logic [HDR_BYTES*8-1:0] word_cnt_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream into little-endian 32-bit words; one-cycle word_valid pulse per word.
module imem_word_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic        last_lane,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  lane_reg;
   logic [23:0] low_reg;
   logic        word_valid_reg;
   logic [31:0] word_reg;

   assign last_lane  = (lane_reg == 2'd3);
   assign word_valid = word_valid_reg;
   assign word       = word_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane_reg       <= '0;
         low_reg        <= '0;
         word_valid_reg <= 1'b0;
         word_reg       <= '0;
      end else begin
         word_valid_reg <= byte_en && last_lane && !clr;
         if (clr) begin
            lane_reg <= '0;
         end else if (byte_en) begin
            lane_reg <= lane_reg + 2'd1;
            // The fourth byte bypasses the holding register straight into the word
            if (last_lane) begin
               word_reg <= {byte_data, low_reg};
            end else begin
               for (int k = 0; k < 3; k++) begin
                  if (lane_reg == 2'(k)) low_reg[8*k +: 8] <= byte_data;
               end
            end
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: header + payload byte stream to sequential imem word writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W      = 14,
   parameter int DEPTH_WORDS = 2048
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_valid,
   input  logic [7:0]        i_data,
   output logic              o_ready,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_waddr,
   output logic [31:0]       o_wdata,
   output logic              o_core_rst,
   output logic              o_done,
   output logic              o_err
);

   state_t              state_reg, state_next;
   logic                ready_reg;
   logic                done_reg, err_reg, core_rst_reg;
   word_cnt_t           cnt_reg;
   logic [ADDR_W-3:0]   word_idx_reg;
   logic [ADDR_W-1:0]   waddr_reg;

   logic      xfer, start_ok, data_xfer, last_lane, last_word;
   word_cnt_t hdr_count;

   assign xfer      = i_valid && ready_reg;
   assign start_ok  = i_start && (state_reg inside {IDLE, DONE, ERR});
   assign data_xfer = xfer && (state_reg == DATA);
   // Header bytes shift in from the top, so after CNT_HI the register holds {CNT_HI, CNT_LO}
   assign hdr_count = {i_data, cnt_reg[HDR_BYTES*8-1:8]};
   assign last_word = (word_cnt_t'(word_idx_reg) == cnt_reg - 1'b1);

   imem_word_packer u_packer (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .clr        (start_ok),
      .byte_en    (data_xfer),
      .byte_data  (i_data),
      .last_lane  (last_lane),
      .word_valid (o_we),
      .word       (o_wdata)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] csum_reg;
   logic       csum_ok;

   assign csum_ok = ((csum_reg ^ i_data) == 8'h00);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || start_ok) csum_reg <= '0;
      else if (data_xfer)       csum_reg <= csum_reg ^ i_data;
   end
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, DONE, ERR: if (i_start) state_next = HDR0;
         HDR0:            if (xfer) state_next = HDR1;
         HDR1: begin
            if (xfer) begin
               if (hdr_count == '0)                           state_next = DONE;
               else if (hdr_count > word_cnt_t'(DEPTH_WORDS)) state_next = ERR;
               else                                           state_next = DATA;
            end
         end
         DATA: begin
            if (data_xfer && last_lane && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_next = CSUM;
`else
               state_next = DONE;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM:            if (xfer) state_next = csum_ok ? DONE : ERR;
`endif
         default:         state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         ready_reg    <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         core_rst_reg <= 1'b1;
         cnt_reg      <= '0;
         word_idx_reg <= '0;
         waddr_reg    <= '0;
      end else begin
         ready_reg <= (state_next inside {HDR0, HDR1, DATA, CSUM});
         if (start_ok) begin
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            core_rst_reg <= 1'b1;
            cnt_reg      <= '0;
            word_idx_reg <= '0;
         end
         if (xfer && (state_reg inside {HDR0, HDR1})) cnt_reg <= hdr_count;
         if (data_xfer && last_lane) begin
            waddr_reg    <= {word_idx_reg, 2'b00};
            word_idx_reg <= word_idx_reg + 1'b1;
         end
         if (state_next == DONE && state_reg != DONE) begin
            done_reg     <= 1'b1;
            core_rst_reg <= 1'b0;
         end
         if (state_next == ERR && state_reg != ERR) err_reg <= 1'b1;
      end
   end

   assign o_ready    = ready_reg;
   assign o_waddr    = waddr_reg;
   assign o_done     = done_reg;
   assign o_err      = err_reg;
   assign o_core_rst = core_rst_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus time, popped on o_we.
// Define IMEM_LOADER_CHECKSUM_EN for both RTL and bench to exercise the checksum build.
module tb_imem_loader;

   localparam int ADDR_W      = 14;
   localparam int DEPTH_WORDS = 2048;

   logic              i_clk = 1'b0;
   logic              i_rst_n, i_start, i_valid;
   logic [7:0]        i_data;
   logic              o_ready, o_we, o_core_rst, o_done, o_err;
   logic [ADDR_W-1:0] o_waddr;
   logic [31:0]       o_wdata;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] img [0:7];
   int          n_cmp = 0;
   int          n_err = 0;

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH_WORDS)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_start    (i_start),
      .i_valid    (i_valid),
      .i_data     (i_data),
      .o_ready    (o_ready),
      .o_we       (o_we),
      .o_waddr    (o_waddr),
      .o_wdata    (o_wdata),
      .o_core_rst (o_core_rst),
      .o_done     (o_done),
      .o_err      (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Write monitor: every o_we must match the oldest queued expectation
   initial begin
      wr_t e;
      forever begin
         @(negedge i_clk);
         if (o_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("we_unexpected", 32'(o_we), 32'd0);
            end else begin
               e = exp_q.pop_front();
               $display("write addr=0x%03h data=0x%08h (exp 0x%03h 0x%08h)", o_waddr, o_wdata, e.addr, e.data);
               check("waddr", 32'(o_waddr), 32'(e.addr));
               check("wdata", o_wdata, e.data);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic pulse_start();
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int budget;
      budget = 0;
      if (gaps) begin
         for (int g = 0; g < 4 && $urandom_range(1) == 1; g++) begin
            i_valid = 1'b0;
            @(negedge i_clk);
         end
      end
      i_valid = 1'b1;
      i_data  = b;
      while (!o_ready && budget < 32) begin
         @(negedge i_clk);
         budget++;
      end
      if (!o_ready) begin
         check("ready_timeout", 32'(o_ready), 32'd1);
         i_valid = 1'b0;
         return;
      end
      @(negedge i_clk);
      i_valid = 1'b0;
   endtask

   task automatic send_header(input logic [15:0] n);
      send_byte(n[7:0], 1'b0);
      send_byte(n[15:8], 1'b0);
   endtask

   task automatic send_words(input int first, input int nwords, input bit gaps, output logic [7:0] cs);
      wr_t e;
      cs = 8'h00;
      for (int w = first; w < first + nwords; w++) begin
         for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
               e.addr = ADDR_W'(w * 4);
               e.data = img[w];
               exp_q.push_back(e);
            end
            cs = cs ^ img[w][8*k +: 8];
            send_byte(img[w][8*k +: 8], gaps);
         end
      end
   endtask

   task automatic wait_end(input string tag, input bit expect_err);
      int budget;
      budget = 0;
      while (!o_done && !o_err && budget < 16) begin
         @(negedge i_clk);
         budget++;
      end
      @(negedge i_clk);
      check({tag, "_done"}, 32'(o_done), 32'(!expect_err));
      check({tag, "_err"}, 32'(o_err), 32'(expect_err));
      check({tag, "_core_rst"}, 32'(o_core_rst), 32'(expect_err));
      check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic load_image(input string tag, input int nwords, input bit gaps);
      logic [7:0] cs;
      pulse_start();
      check({tag, "_start_core_rst"}, 32'(o_core_rst), 32'd1);
      check({tag, "_start_done"}, 32'(o_done), 32'd0);
      send_header(16'(nwords));
      send_words(0, nwords, gaps, cs);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(cs, gaps);
`endif
      wait_end(tag, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(o_ready), 32'd0);
      check({tag, "_we"}, 32'(o_we), 32'd0);
      check({tag, "_waddr"}, 32'(o_waddr), 32'd0);
      check({tag, "_wdata"}, o_wdata, 32'd0);
      check({tag, "_done"}, 32'(o_done), 32'd0);
      check({tag, "_err"}, 32'(o_err), 32'd0);
      check({tag, "_core_rst"}, 32'(o_core_rst), 32'd1);
   endtask

   initial begin
      logic [7:0] cs;
      i_rst_n = 1'b0;
      i_start = 1'b0;
      i_valid = 1'b0;
      i_data  = 8'h00;
      repeat (3) @(negedge i_clk);
      check_reset_outputs("rst");
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // 1) two-word image, one byte per cycle
      img[0] = 32'h0000_0013;
      img[1] = 32'h0010_0093;
      load_image("t1", 2, 1'b0);

      // 2) empty image: done exactly one cycle after CNT_HI
      pulse_start();
      check("t2_restart_core_rst", 32'(o_core_rst), 32'd1);
      send_header(16'h0000);
      check("t2_done", 32'(o_done), 32'd1);
      check("t2_core_rst", 32'(o_core_rst), 32'd0);
      check("t2_ready", 32'(o_ready), 32'd0);

      // 3) oversize header, then a good image
      pulse_start();
      send_header(16'(DEPTH_WORDS + 1));
      check("t3_err", 32'(o_err), 32'd1);
      check("t3_core_rst", 32'(o_core_rst), 32'd1);
      check("t3_ready", 32'(o_ready), 32'd0);
      check("t3_done", 32'(o_done), 32'd0);
      load_image("t3b", 1, 1'b0);

      // 4) three-word image with random valid gaps
      img[0] = 32'hDEAD_BEEF;
      img[1] = 32'h0123_4567;
      img[2] = 32'h89AB_CDEF;
      load_image("t4", 3, 1'b1);

      // 5) reset after six payload bytes, then a fresh load from address 0
      pulse_start();
      send_header(16'd3);
      send_words(0, 1, 1'b0, cs);
      send_byte(img[1][7:0], 1'b0);
      send_byte(img[1][15:8], 1'b0);
      @(negedge i_clk);
      check("t5_pending", 32'(exp_q.size()), 32'd0);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      check_reset_outputs("t5_rst");
      i_rst_n = 1'b1;
      @(negedge i_clk);
      img[0] = 32'h0000_0013;
      load_image("t5b", 1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // 6) checksum good and bad
      img[0] = 32'h0000_0013;
      pulse_start();
      send_header(16'd1);
      send_words(0, 1, 1'b0, cs);
      send_byte(8'h13, 1'b0);
      wait_end("t6_good", 1'b0);
      pulse_start();
      send_header(16'd1);
      send_words(0, 1, 1'b0, cs);
      send_byte(8'h12, 1'b0);
      wait_end("t6_bad", 1'b1);
`endif

      repeat (2) @(negedge i_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
